// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed memory slave for the multicycle ARM core.
//               Accepts one request in IDLE, inserts WAIT_CYCLES wait states,
//               then pulses MemReady for one cycle. Misaligned or
//               out-of-range accesses are flagged with MemErr and never
//               touch storage.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          write_q;
    logic          err_q;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          w_accept;
    logic          w_req_err;
    logic          w_enter_resp;
    logic [AW-1:0] w_txn_idx;
    logic [31:0]   w_txn_wdata;
    logic          w_txn_write;
    logic          w_txn_err;
    logic          w_mem_we;

    // Request decode; with zero wait states RESP is entered on the accept
    // edge itself, so the transaction fields come straight from the inputs.
    always_comb begin
        w_accept     = (state_q == S_IDLE) && MemReq && reset;
        w_req_err    = (Adr[1:0] != 2'b00) || (Adr >= ADR_LIMIT);
        w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                       ((state_q == S_WAIT) && (cnt_q <= 4'd1));
        if (state_q == S_IDLE) begin
            w_txn_idx   = Adr[AW+1:2];
            w_txn_wdata = WriteData;
            w_txn_write = MemWrite;
            w_txn_err   = w_req_err;
        end else begin
            w_txn_idx   = idx_q;
            w_txn_wdata = wdata_q;
            w_txn_write = write_q;
            w_txn_err   = err_q;
        end
        w_mem_we = w_enter_resp && w_txn_write && !w_txn_err;
    end

    // Next-state, wait counter and read-data selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (w_enter_resp && !w_txn_write) begin
            rdata_d = w_txn_err ? 32'h0000_0000 : mem_q[w_txn_idx];
        end
    end

    // Control state and latched request fields; reset aborts any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (w_accept) begin
                idx_q   <= Adr[AW+1:2];
                wdata_q <= WriteData;
                write_q <= MemWrite;
                err_q   <= w_req_err;
            end
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_txn_idx] <= w_txn_wdata;
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = (state_q == S_RESP);
    assign MemErr   = (state_q == S_RESP) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. A word-array model
//               predicts read data, error flags and response timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int W = 2;

    logic        clk;
    logic        reset;
    logic        MemReq, MemWrite;
    logic [31:0] Adr, WriteData, ReadData;
    logic        MemReady, MemErr;

    logic        z_MemReq, z_MemWrite;
    logic [31:0] z_Adr, z_WriteData, z_ReadData;
    logic        z_MemReady, z_MemErr;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
        .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
        .MemReady(MemReady), .MemErr(MemErr)
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MemReq(z_MemReq), .MemWrite(z_MemWrite),
        .Adr(z_Adr), .WriteData(z_WriteData), .ReadData(z_ReadData),
        .MemReady(z_MemReady), .MemErr(z_MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd256);
    endfunction

    // One complete transaction on the WAIT_CYCLES=2 instance with timing,
    // error and read-data checks against the model.
    task automatic run_txn(input logic wr, input logic [31:0] adr, input logic [31:0] wd);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        got_err;
        logic [31:0] got_rd;
        bit          tim_ok;
        exp_err = addr_bad(adr);
        @(negedge clk);
        MemReq = 1'b1; MemWrite = wr; Adr = adr; WriteData = wd;
        @(posedge clk);
        if (wr) exp_rd = ref_rdata;
        else    exp_rd = exp_err ? 32'h0 : ref_mem[adr[7:2]];
        if (wr && !exp_err) ref_mem[adr[7:2]] = wd;
        ref_rdata = exp_rd;
        tim_ok  = 1'b1;
        got_err = 1'b0;
        got_rd  = 32'h0;
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                MemReq = 1'b0; MemWrite = 1'($urandom);
                Adr = $urandom; WriteData = $urandom;
            end
            if (MemReady !== 1'(k == W)) tim_ok = 1'b0;
            if (k == W) begin got_err = MemErr; got_rd = ReadData; end
        end
        tests++;
        if (!tim_ok) begin
            fails++;
            $display("FAIL txn_timing adr=%h wr=%0b: MemReady not a single pulse after edge E0+%0d", adr, wr, W);
        end
        tests++;
        if (got_err !== exp_err) begin
            fails++;
            $display("FAIL txn_err adr=%h wr=%0b: got %0b expected %0b", adr, wr, got_err, exp_err);
        end
        tests++;
        if (got_rd !== exp_rd) begin
            fails++;
            $display("FAIL txn_rdata adr=%h wr=%0b: got %h expected %h", adr, wr, got_rd, exp_rd);
        end
    endtask

    task automatic test_reset;
        bit ok;
        reset = 1'b0; MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h0; WriteData = 32'h0;
        z_MemReq = 1'b1; z_MemWrite = 1'b0; z_Adr = 32'h0; z_WriteData = 32'h0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (MemReady !== 1'b0 || MemErr !== 1'b0 || ReadData !== 32'h0 ||
                z_MemReady !== 1'b0 || z_ReadData !== 32'h0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_values: rdy=%0b err=%0b rd=%h, required 0/0/0", MemReady, MemErr, ReadData);
        end
        MemReq = 1'b0; z_MemReq = 1'b0;
        reset = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (MemReady !== 1'b0 || z_MemReady !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_release: MemReady=%0b pulsed without a new request, required 0", MemReady);
        end
        ref_rdata = 32'h0;
    endtask

    task automatic fill_memory;
        for (int i = 0; i < 64; i++) run_txn(1'b1, 32'(i * 4), $urandom);
    endtask

    task automatic test_write_read;
        run_txn(1'b1, 32'h10, 32'h1234_5678);
        run_txn(1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (ReadData !== 32'h1234_5678 || MemReady !== 1'b0) begin
                fails++;
                $display("FAIL rdata_hold idle%0d: rd=%h rdy=%0b, required 12345678/0", i, ReadData, MemReady);
            end
        end
    endtask

    task automatic test_errors;
        run_txn(1'b0, 32'h13, 32'h0);
        run_txn(1'b1, 32'h100, 32'hFFFF_FFFF);
        run_txn(1'b0, 32'h0, 32'h0);
        run_txn(1'b1, 32'h102, 32'hDEAD_BEEF);
        run_txn(1'b0, 32'hFC, 32'h0);
    endtask

    task automatic test_reset_mid_write;
        bit ok;
        @(negedge clk);
        MemReq = 1'b1; MemWrite = 1'b1; Adr = 32'h20; WriteData = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        MemReq = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (MemReady !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_abort: MemReady=%0b during reset, required 0", MemReady);
        end
        reset = 1'b1;
        ref_rdata = 32'h0;
        @(negedge clk);
        tests++;
        if (ReadData !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h expected 00000000", ReadData);
        end
        run_txn(1'b0, 32'h20, 32'h0);
    endtask

    task automatic test_stream;
        logic exp_rdy;
        @(negedge clk);
        MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h0; WriteData = 32'h0;
        @(posedge clk);
        for (int t = 0; t < 4 * (W + 2); t++) begin
            @(negedge clk);
            exp_rdy = 1'((t % (W + 2)) == W);
            tests++;
            if (MemReady !== exp_rdy) begin
                fails++;
                $display("FAIL stream_pulse t=%0d: got %0b expected %0b", t, MemReady, exp_rdy);
            end
            if (exp_rdy) begin
                tests++;
                if (ReadData !== ref_mem[t / (W + 2)] || MemErr !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_rdata word%0d: got %h err=%0b expected %h err=0",
                             t / (W + 2), ReadData, MemErr, ref_mem[t / (W + 2)]);
                end
                if (t / (W + 2) < 3) Adr = 32'(4 * (t / (W + 2) + 1));
                else                 MemReq = 1'b0;
            end
        end
        ref_rdata = ref_mem[3];
    endtask

    task automatic test_random;
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 1) a = 32'h100 + {$urandom_range(0, 1000), 2'b00};
            else               a = {24'h0, 6'($urandom), 2'b00};
            run_txn(1'($urandom), a, $urandom);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] word;
        logic        exp_rdy;
        word = $urandom;
        @(negedge clk);
        z_MemReq = 1'b1; z_MemWrite = 1'b1; z_Adr = 32'h4; z_WriteData = word;
        @(posedge clk);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t == 0) z_MemWrite = 1'b0;
            if (t == 4) z_MemReq = 1'b0;
            exp_rdy = 1'((t % 2) == 0);
            tests++;
            if (z_MemReady !== exp_rdy || z_MemErr !== 1'b0) begin
                fails++;
                $display("FAIL zero_wait_pulse t=%0d: rdy=%0b err=%0b expected rdy=%0b err=0",
                         t, z_MemReady, z_MemErr, exp_rdy);
            end
            if (t == 2 || t == 4) begin
                tests++;
                if (z_ReadData !== word) begin
                    fails++;
                    $display("FAIL zero_wait_rdata t=%0d: got %h expected %h", t, z_ReadData, word);
                end
            end
        end
        @(negedge clk);
        tests++;
        if (z_MemReady !== 1'b0) begin
            fails++;
            $display("FAIL zero_wait_idle: MemReady=%0b after requests stopped, required 0", z_MemReady);
        end
    endtask

    initial begin
        ref_rdata = 32'h0;
        test_reset();
        fill_memory();
        test_write_read();
        test_errors();
        test_reset_mid_write();
        test_stream();
        test_random();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
